// File: rtl/pipe_pkg.sv
// Shared widths and ID/EX bundle layout for the 5-stage RISC-V pipeline registers.
package pipe_pkg;

  localparam int XLEN      = 32;
  localparam int REGADDR_W = 5;

  // Bundle widths: IF/ID = {PC, Instr, PCPlus4}; EX/MEM and MEM/WB = three words plus Rd.
  localparam int IFID_W  = 3 * XLEN;
  localparam int IDEX_W  = 6 * XLEN + 3 * REGADDR_W;
  localparam int EXMEM_W = 3 * XLEN + REGADDR_W;
  localparam int MEMWB_W = 3 * XLEN + REGADDR_W;

  localparam int IDEX_PCPLUS4_LSB = 0;
  localparam int IDEX_IMMEXT_LSB  = IDEX_PCPLUS4_LSB + XLEN;
  localparam int IDEX_RD_LSB      = IDEX_IMMEXT_LSB + XLEN;
  localparam int IDEX_RS2_LSB     = IDEX_RD_LSB + REGADDR_W;
  localparam int IDEX_RS1_LSB     = IDEX_RS2_LSB + REGADDR_W;
  localparam int IDEX_INSTR_LSB   = IDEX_RS1_LSB + REGADDR_W;
  localparam int IDEX_PC_LSB      = IDEX_INSTR_LSB + XLEN;
  localparam int IDEX_RD2_LSB     = IDEX_PC_LSB + XLEN;
  localparam int IDEX_RD1_LSB     = IDEX_RD2_LSB + XLEN;

  // Field order matches the offsets above, most significant field first.
  typedef struct packed {
    logic [XLEN-1:0]      rd1;
    logic [XLEN-1:0]      rd2;
    logic [XLEN-1:0]      pc;
    logic [XLEN-1:0]      instr;
    logic [REGADDR_W-1:0] rs1;
    logic [REGADDR_W-1:0] rs2;
    logic [REGADDR_W-1:0] rd;
    logic [XLEN-1:0]      immext;
    logic [XLEN-1:0]      pcplus4;
  } idex_t;

  function automatic logic [REGADDR_W-1:0] idex_rd(input logic [IDEX_W-1:0] bundle);
    return bundle[IDEX_RD_LSB +: REGADDR_W];
  endfunction

endpackage

// File: rtl/pipe_stage_elastic_sat_counter.sv
// Saturating up-counter used for the pipeline stage debug statistics.
module sat_counter
  import pipe_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count up on inc, sticking at all-ones until reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic valid/ready pipeline register with optional skid entry, flush and debug counters.
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int WIDTH      = IDEX_W,
  parameter int SKID       = 0,
  parameter int CLEAR_DATA = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic             main_valid_r;
  logic [WIDTH-1:0] main_data_r;
  logic             skid_valid_s;
  logic             in_fire_s;
  logic             out_fire_s;
  logic             stall_inc_s;
  logic             flush_inc_s;

  assign in_fire_s  = in_valid & in_ready;
  assign out_fire_s = main_valid_r & out_ready;
  assign out_valid  = main_valid_r;
  assign out_data   = main_data_r;

  if (SKID == 0) begin : g_single
    assign in_ready     = ~main_valid_r | out_ready;
    assign skid_valid_s = 1'b0;

    // Single entry: flush wins, then load, then drain.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        main_valid_r <= 1'b0;
        main_data_r  <= '0;
      end else if (flush) begin
        main_valid_r <= 1'b0;
        if (CLEAR_DATA != 0) begin
          main_data_r <= '0;
        end
      end else if (in_fire_s) begin
        main_valid_r <= 1'b1;
        main_data_r  <= in_data;
      end else if (out_fire_s) begin
        main_valid_r <= 1'b0;
      end
    end
  end else begin : g_skid
    logic             skid_valid_r;
    logic             in_ready_r;
    logic [WIDTH-1:0] skid_data_r;

    assign in_ready     = in_ready_r;
    assign skid_valid_s = skid_valid_r;

    // in_ready_r mirrors !skid_valid_r so upstream sees a pure flop.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        main_valid_r <= 1'b0;
        main_data_r  <= '0;
        skid_valid_r <= 1'b0;
        skid_data_r  <= '0;
        in_ready_r   <= 1'b1;
      end else if (flush) begin
        main_valid_r <= 1'b0;
        skid_valid_r <= 1'b0;
        in_ready_r   <= 1'b1;
        if (CLEAR_DATA != 0) begin
          main_data_r <= '0;
          skid_data_r <= '0;
        end
      end else if (out_fire_s && skid_valid_r) begin
        main_data_r  <= skid_data_r;
        skid_valid_r <= 1'b0;
        in_ready_r   <= 1'b1;
      end else if (in_fire_s && (!main_valid_r || out_ready)) begin
        main_valid_r <= 1'b1;
        main_data_r  <= in_data;
      end else if (in_fire_s) begin
        skid_valid_r <= 1'b1;
        skid_data_r  <= in_data;
        in_ready_r   <= 1'b0;
      end else if (out_fire_s) begin
        main_valid_r <= 1'b0;
      end
    end
  end

  assign stall_inc_s = main_valid_r & ~out_ready;
  assign flush_inc_s = flush & (main_valid_r | skid_valid_s);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_inc_s),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush_inc_s),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Scoreboard bench: four configurations of pipe_stage_elastic exercised one at a time.
module tb_pipe_stage_elastic;

  logic        clk = 1'b0;
  logic        reset;
  logic        fl[4];
  logic        iv[4];
  logic        ordy[4];
  logic [31:0] id[4];
  logic        iry[4];
  logic        ov[4];
  logic [31:0] od[4];
  logic [15:0] sc[3];
  logic [15:0] fc[3];
  logic [3:0]  sc3;
  logic [3:0]  fc3;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          inst;
    logic [31:0] data;
  } exp_t;
  exp_t sbq[$];

  always #5 clk = ~clk;

  // u0: single register; u1: skid, clearing; u2: skid, non-clearing; u3: single, 4-bit counters
  pipe_stage_elastic #(.WIDTH(32), .SKID(0), .CLEAR_DATA(1), .CNT_W(16)) u0 (
    .clk(clk), .reset(reset), .flush(fl[0]), .in_valid(iv[0]), .in_ready(iry[0]),
    .in_data(id[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]),
    .stall_cnt(sc[0]), .flush_cnt(fc[0]));
  pipe_stage_elastic #(.WIDTH(32), .SKID(1), .CLEAR_DATA(1), .CNT_W(16)) u1 (
    .clk(clk), .reset(reset), .flush(fl[1]), .in_valid(iv[1]), .in_ready(iry[1]),
    .in_data(id[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]),
    .stall_cnt(sc[1]), .flush_cnt(fc[1]));
  pipe_stage_elastic #(.WIDTH(32), .SKID(1), .CLEAR_DATA(0), .CNT_W(16)) u2 (
    .clk(clk), .reset(reset), .flush(fl[2]), .in_valid(iv[2]), .in_ready(iry[2]),
    .in_data(id[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od[2]),
    .stall_cnt(sc[2]), .flush_cnt(fc[2]));
  pipe_stage_elastic #(.WIDTH(32), .SKID(0), .CLEAR_DATA(1), .CNT_W(4)) u3 (
    .clk(clk), .reset(reset), .flush(fl[3]), .in_valid(iv[3]), .in_ready(iry[3]),
    .in_data(id[3]), .out_valid(ov[3]), .out_ready(ordy[3]), .out_data(od[3]),
    .stall_cnt(sc3), .flush_cnt(fc3));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int k, input logic [31:0] d);
    exp_t e;
    e.inst = k;
    e.data = d;
    sbq.push_back(e);
  endtask

  // Pop and compare every handoff seen by any instance.
  always @(negedge clk) begin
    if (!reset) begin
      for (int k = 0; k < 4; k++) begin
        if (ov[k] && ordy[k]) begin
          checks++;
          if (sbq.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected inst %0d got %h exp none", k, od[k]);
          end else begin
            exp_t e;
            e = sbq.pop_front();
            if (e.inst != k || od[k] !== e.data) begin
              errors++;
              $display("FAIL sb_data inst %0d got %h exp inst %0d data %h", k, od[k], e.inst, e.data);
            end
          end
        end
      end
    end
  end

  task automatic test_reset();
    #3;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (ov[k] !== 1'b0 || iry[k] !== 1'b1 || od[k] !== 32'h0) begin
        errors++;
        $display("FAIL reset_state inst %0d got v=%b r=%b d=%h exp v=0 r=1 d=0", k, ov[k], iry[k], od[k]);
      end
    end
    checks++;
    if (sc[0] !== 16'h0 || fc[1] !== 16'h0 || sc3 !== 4'h0 || fc3 !== 4'h0) begin
      errors++;
      $display("FAIL reset_cnt got %h %h %h %h exp 0", sc[0], fc[1], sc3, fc3);
    end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_single();
    iv[0] = 1'b1;
    ordy[0] = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      id[0] = 32'(i);
      push(0, 32'(i));
      tick();
      checks++;
      if (ov[0] !== 1'b1 || od[0] !== 32'(i)) begin
        errors++;
        $display("FAIL single_b2b cyc %0d got v=%b d=%h exp v=1 d=%h", i, ov[0], od[0], 32'(i));
      end
    end
    iv[0] = 1'b0;
    tick();
    checks++;
    if (ov[0] !== 1'b0 || sc[0] !== 16'h0) begin
      errors++;
      $display("FAIL single_drain got v=%b stall=%0d exp v=0 stall=0", ov[0], sc[0]);
    end
    iv[0] = 1'b1;
    id[0] = 32'h5;
    ordy[0] = 1'b0;
    push(0, 32'h5);
    tick();
    iv[0] = 1'b0;
    checks++;
    if (iry[0] !== 1'b0 || ov[0] !== 1'b1) begin
      errors++;
      $display("FAIL single_stall_ready got r=%b v=%b exp r=0 v=1", iry[0], ov[0]);
    end
    repeat (3) tick();
    checks++;
    if (ov[0] !== 1'b1 || od[0] !== 32'h5 || sc[0] !== 16'd3) begin
      errors++;
      $display("FAIL single_hold got v=%b d=%h stall=%0d exp v=1 d=5 stall=3", ov[0], od[0], sc[0]);
    end
    ordy[0] = 1'b1;
    #1;
    checks++;
    if (iry[0] !== 1'b1) begin
      errors++;
      $display("FAIL single_ready_comb got %b exp 1", iry[0]);
    end
    tick();
    checks++;
    if (ov[0] !== 1'b0) begin
      errors++;
      $display("FAIL single_release got v=%b exp 0", ov[0]);
    end
    // Flush while empty: the offered payload is discarded and nothing is counted.
    fl[0] = 1'b1;
    iv[0] = 1'b1;
    id[0] = 32'h77;
    tick();
    fl[0] = 1'b0;
    iv[0] = 1'b0;
    checks++;
    if (ov[0] !== 1'b0 || od[0] !== 32'h0 || fc[0] !== 16'h0) begin
      errors++;
      $display("FAIL single_flush_empty got v=%b d=%h fc=%0d exp v=0 d=0 fc=0", ov[0], od[0], fc[0]);
    end
  endtask

  task automatic test_skid();
    ordy[1] = 1'b0;
    iv[1] = 1'b1;
    id[1] = 32'hA;
    push(1, 32'hA);
    tick();
    checks++;
    if (iry[1] !== 1'b1 || ov[1] !== 1'b1 || od[1] !== 32'hA) begin
      errors++;
      $display("FAIL skid_load got r=%b v=%b d=%h exp r=1 v=1 d=a", iry[1], ov[1], od[1]);
    end
    id[1] = 32'hB;
    push(1, 32'hB);
    tick();
    checks++;
    if (iry[1] !== 1'b0 || od[1] !== 32'hA) begin
      errors++;
      $display("FAIL skid_full got r=%b d=%h exp r=0 d=a", iry[1], od[1]);
    end
    id[1] = 32'hC;
    tick();
    checks++;
    if (iry[1] !== 1'b0 || od[1] !== 32'hA) begin
      errors++;
      $display("FAIL skid_refuse got r=%b d=%h exp r=0 d=a", iry[1], od[1]);
    end
    ordy[1] = 1'b1;
    tick();
    checks++;
    if (ov[1] !== 1'b1 || od[1] !== 32'hB || iry[1] !== 1'b1) begin
      errors++;
      $display("FAIL skid_move got v=%b d=%h r=%b exp v=1 d=b r=1", ov[1], od[1], iry[1]);
    end
    push(1, 32'hC);
    tick();
    iv[1] = 1'b0;
    checks++;
    if (ov[1] !== 1'b1 || od[1] !== 32'hC) begin
      errors++;
      $display("FAIL skid_third got v=%b d=%h exp v=1 d=c", ov[1], od[1]);
    end
    tick();
    checks++;
    if (ov[1] !== 1'b0 || sc[1] !== 16'd2) begin
      errors++;
      $display("FAIL skid_stall_cnt got v=%b stall=%0d exp v=0 stall=2", ov[1], sc[1]);
    end
  endtask

  task automatic test_flush_full();
    ordy[1] = 1'b0;
    iv[1] = 1'b1;
    id[1] = 32'h11;
    tick();
    id[1] = 32'h22;
    tick();
    fl[1] = 1'b1;
    id[1] = 32'hD;
    tick();
    fl[1] = 1'b0;
    iv[1] = 1'b0;
    checks++;
    if (ov[1] !== 1'b0 || od[1] !== 32'h0 || iry[1] !== 1'b1 || fc[1] !== 16'd1) begin
      errors++;
      $display("FAIL flush_full got v=%b d=%h r=%b fc=%0d exp v=0 d=0 r=1 fc=1", ov[1], od[1], iry[1], fc[1]);
    end
    ordy[1] = 1'b1;
    repeat (2) tick();
    checks++;
    if (ov[1] !== 1'b0) begin
      errors++;
      $display("FAIL flush_no_ghost got v=%b exp 0", ov[1]);
    end
  endtask

  task automatic test_flush_noclear();
    fl[2] = 1'b1;
    tick();
    fl[2] = 1'b0;
    checks++;
    if (fc[2] !== 16'h0) begin
      errors++;
      $display("FAIL noclear_empty_flush got fc=%0d exp 0", fc[2]);
    end
    iv[2] = 1'b1;
    ordy[2] = 1'b0;
    id[2] = 32'h55;
    tick();
    iv[2] = 1'b0;
    fl[2] = 1'b1;
    tick();
    fl[2] = 1'b0;
    checks++;
    if (ov[2] !== 1'b0 || od[2] !== 32'h55 || fc[2] !== 16'd1 || iry[2] !== 1'b1) begin
      errors++;
      $display("FAIL noclear_flush got v=%b d=%h fc=%0d r=%b exp v=0 d=55 fc=1 r=1", ov[2], od[2], fc[2], iry[2]);
    end
  endtask

  task automatic test_async_reset();
    ordy[1] = 1'b0;
    iv[1] = 1'b1;
    id[1] = 32'h31;
    tick();
    id[1] = 32'h32;
    tick();
    iv[1] = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (ov[1] !== 1'b0 || od[1] !== 32'h0 || iry[1] !== 1'b1 || sc[1] !== 16'h0 || fc[1] !== 16'h0) begin
      errors++;
      $display("FAIL async_reset got v=%b d=%h r=%b sc=%0d fc=%0d exp all 0 r=1", ov[1], od[1], iry[1], sc[1], fc[1]);
    end
    reset = 1'b0;
    iv[1] = 1'b1;
    ordy[1] = 1'b1;
    id[1] = 32'h99;
    push(1, 32'h99);
    tick();
    iv[1] = 1'b0;
    checks++;
    if (ov[1] !== 1'b1 || od[1] !== 32'h99) begin
      errors++;
      $display("FAIL post_reset_fire got v=%b d=%h exp v=1 d=99", ov[1], od[1]);
    end
    tick();
  endtask

  task automatic test_saturation();
    ordy[3] = 1'b0;
    iv[3] = 1'b1;
    id[3] = 32'hE;
    push(3, 32'hE);
    tick();
    iv[3] = 1'b0;
    repeat (20) tick();
    checks++;
    if (sc3 !== 4'hF || ov[3] !== 1'b1 || od[3] !== 32'hE) begin
      errors++;
      $display("FAIL sat_stall got sc=%0d v=%b d=%h exp sc=15 v=1 d=e", sc3, ov[3], od[3]);
    end
    ordy[3] = 1'b1;
    tick();
    checks++;
    if (sc3 !== 4'hF || ov[3] !== 1'b0) begin
      errors++;
      $display("FAIL sat_hold got sc=%0d v=%b exp sc=15 v=0", sc3, ov[3]);
    end
  endtask

  initial begin
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      fl[k] = 1'b0;
      iv[k] = 1'b0;
      ordy[k] = 1'b0;
      id[k] = 32'h0;
    end
    test_reset();
    test_single();
    test_skid();
    test_flush_full();
    test_flush_noclear();
    sbq.delete();
    test_async_reset();
    test_saturation();
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover got %0d pending exp 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
